dmx_framer: RTL and testbench
=============================

// Module: dmx_framer
// PURPOSE
//  Parametrised DMX512 transmit framer. Generates BREAK, MAB, start-code slot, N data slots and MTBP.
//  Output is a serial mark/space bitstream on dmx_data, which feeds dmx_modulator.
//  Adds runtime slot count, one-shot or continuous framing, a start trigger and status outputs.
//  Slot bytes are fetched by address from an external slot store.
// PARAMETERS
//  CLK_HZ      12_000_000  system clock frequency
//  BAUD        250_000     DMX bit rate; DIV = CLK_HZ/BAUD clocks per bit (default 48)
//  NUM_SLOTS   512         maximum data slots per frame, excluding the start code
//  BREAK_BITS  25          BREAK length in bit times (line space)
//  MAB_BITS    3           mark-after-break length in bit times
//  MTBP_BITS   2           mark-time-between-packets in bit times, after the last slot
//  START_CODE  8'h00       value of slot 0
// PORTS
//  CLK12       in   1   system clock
//  RESET_N     in   1   asynchronous reset, active low
//  enable      in   1   1 = framer may start frames
//  one_shot    in   1   1 = one frame per start pulse; 0 = back-to-back frames while enable
//  start       in   1   one-cycle trigger, used only when one_shot=1
//  num_slots   in   10  data slots per frame; 0 or >NUM_SLOTS means NUM_SLOTS
//  slot_addr   out  10  index (1..n) of the next data slot to be loaded
//  slot_byte   in   8   data for slot_addr
//  dmx_data    out  1   serial line: 1 = mark, 0 = space
//  busy        out  1   high from BREAK entry until MTBP ends
//  frame_done  out  1   one-cycle pulse when the last stop bit of the last slot ends
//  frame_count out  16  completed-frame counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): dmx_data=1, busy=0, frame_done=0, slot_addr=1,
//    frame_count=0, state=S_WAIT, baud counter=DIV-1. The line is mark immediately.
//  - Baud counter counts DIV-1..0 and is held at DIV-1 in S_WAIT. tick = (counter==0).
//    Every bit time is exactly DIV clocks.
//  - States: S_WAIT -> S_BREAK -> S_MAB -> S_SLOTS -> S_MTBP -> (S_BREAK | S_WAIT).
//  - S_WAIT, dmx_data=1: go to S_BREAK when enable && (one_shot ? start : 1).
//    The first space clock is the cycle after the trigger.
//  - On S_BREAK entry: latch n = clamp(num_slots); busy<=1.
//  - S_BREAK: dmx_data=0 for BREAK_BITS ticks. S_MAB: dmx_data=1 for MAB_BITS ticks.
//  - S_SLOTS: each slot is 11 bits, sent in this order:
//    start bit 0, 8 data bits LSB first, 2 stop bits 1.
//    Slot 0 carries START_CODE; slots 1..n carry slot_byte.
//  - Slot load happens on the tick that ends MAB (slot 0) or ends a slot's last stop bit:
//    * slot_byte is sampled for the current slot_addr;
//    * slot_addr then increments.
//    slot_addr is stable >= 11*DIV-1 clocks before it is sampled, so synchronous-read RAM is fine.
//  - When slot n's last stop bit ends: frame_done pulses, go to S_MTBP, slot_addr<=1.
//    Slots load exactly n+1 times per frame.
//  - S_MTBP: dmx_data=1 for MTBP_BITS ticks, then:
//    * if enable && !one_shot: S_BREAK;
//    * else: S_WAIT with busy<=0.
//  - start while busy is ignored (not queued). start with enable=0 is ignored.
//  - enable or one_shot changing mid-frame: current frame completes unchanged;
//    the new values are evaluated only at MTBP end and in S_WAIT.
//  - num_slots changing mid-frame has no effect until the next S_BREAK entry.
//  - All outputs are registered; no combinational path from inputs to dmx_data.
// CONFIGURATION
//  DMX_FRAME_COUNTER_EN defined:
//    frame_count increments (wraps at 16'hFFFF->0) on each frame_done pulse.
//  Not defined: frame_count is tied to 16'h0000 and no counter flops are built.
// TESTING
//  1 Hold RESET_N=0, then release with enable=0 -> dmx_data=1, busy=0, slot_addr=1;
//    stays this way for 10k clocks.
//  2 one_shot=1, num_slots=4, slot_byte=slot_addr, start pulse ->
//    * 1200 clocks space, 144 mark;
//    * slots 00,01,02,03,04 at 528 clocks each;
//    * frame_done once, 96 mark, busy=0.
//  3 one_shot=0, enable=1, num_slots=0 -> 513 slots per frame;
//    the next BREAK begins exactly 96 clocks after frame_done; 3 frames decoded correctly.
//  4 Continuous mode, drop enable mid-slot 7 of 10 -> frame completes through slot 10 and MTBP,
//    then S_WAIT; start pulses while busy produce no extra frame.
//  5 Assert RESET_N=0 during BREAK -> dmx_data=1 within the same cycle (async);
//    busy=0; a new frame needs a new trigger.
//  6 DMX_FRAME_COUNTER_EN, 3 one-shot frames -> frame_count=3;
//    without the macro, frame_count=0 throughout.

Source files
------------

// File: rtl/dmx_framer.sv
// DMX512 transmit framer: BREAK, MAB, start-code slot, N data slots (8N2) and MTBP on a mark/space line.
// Define DMX_FRAME_COUNTER_EN to build the completed-frame counter; otherwise frame_count is tied to zero.
module dmx_framer #(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned BAUD       = 250_000,
  parameter int unsigned NUM_SLOTS  = 512,
  parameter int unsigned BREAK_BITS = 25,
  parameter int unsigned MAB_BITS   = 3,
  parameter int unsigned MTBP_BITS  = 2,
  parameter logic [7:0]  START_CODE = 8'h00
) (
  input  logic        CLK12,
  input  logic        RESET_N,
  input  logic        enable,
  input  logic        one_shot,
  input  logic        start,
  input  logic [9:0]  num_slots,
  output logic [9:0]  slot_addr,
  input  logic [7:0]  slot_byte,
  output logic        dmx_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned DIV       = CLK_HZ / BAUD;
  localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SLOT_BITS = 11;
  localparam int unsigned MAX_A     = (BREAK_BITS > SLOT_BITS) ? BREAK_BITS : SLOT_BITS;
  localparam int unsigned MAX_B     = (MAB_BITS > MTBP_BITS) ? MAB_BITS : MTBP_BITS;
  localparam int unsigned MAXB      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned BW        = $clog2(MAXB);

  localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
  localparam logic [9:0]    SLOT_MAX = 10'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_WAIT,
    S_BREAK,
    S_MAB,
    S_SLOTS,
    S_MTBP
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic [9:0]      slot_reg, slot_next;
  logic [9:0]      n_reg, n_next;
  logic [9:0]      addr_reg, addr_next;
  logic [10:0]     sh_reg, sh_next, sh_shift;
  logic            dmx_reg, dmx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            tick, last_bit, phase_end, last_slot, trigger;
  logic            load_start, load_data, frame_end, enter_break;

  assign tick      = (cnt_reg == '0);
  assign phase_end = tick && last_bit;
  assign last_slot = (slot_reg == n_reg);
  assign trigger   = enable && (one_shot ? start : 1'b1);

  always_comb begin
    last_bit = 1'b0;
    case (state_reg)
      S_BREAK: last_bit = (bit_reg == BW'(BREAK_BITS - 1));
      S_MAB:   last_bit = (bit_reg == BW'(MAB_BITS - 1));
      S_SLOTS: last_bit = (bit_reg == BW'(SLOT_BITS - 1));
      S_MTBP:  last_bit = (bit_reg == BW'(MTBP_BITS - 1));
      default: last_bit = 1'b0;
    endcase
  end

  // Line shifts LSB first; vacated positions fill with mark.
  for (genvar gi = 0; gi < 10; gi++) begin : g_shift
    assign sh_shift[gi] = sh_reg[gi+1];
  end
  assign sh_shift[10] = 1'b1;

  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= S_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:  if (trigger) state_next = S_BREAK;
      S_BREAK: if (phase_end) state_next = S_MAB;
      S_MAB:   if (phase_end) state_next = S_SLOTS;
      S_SLOTS: if (phase_end && last_slot) state_next = S_MTBP;
      S_MTBP:  if (phase_end) state_next = (enable && !one_shot) ? S_BREAK : S_WAIT;
      default: state_next = S_WAIT;
    endcase
  end

  always_comb begin
    load_start  = (state_reg == S_MAB) && phase_end;
    load_data   = (state_reg == S_SLOTS) && phase_end && !last_slot;
    frame_end   = (state_reg == S_SLOTS) && phase_end && last_slot;
    enter_break = (state_next == S_BREAK) && (state_reg != S_BREAK);

    // Counter stays parked at the top in S_WAIT so the first BREAK bit is a full DIV clocks.
    if ((state_reg == S_WAIT) || tick) begin
      cnt_next = CNT_TOP;
    end else begin
      cnt_next = cnt_reg - 1'b1;
    end

    if ((state_reg == S_WAIT) || phase_end) begin
      bit_next = '0;
    end else if (tick) begin
      bit_next = bit_reg + 1'b1;
    end else begin
      bit_next = bit_reg;
    end

    if (load_start) begin
      sh_next = {2'b11, START_CODE, 1'b0};
    end else if (load_data) begin
      sh_next = {2'b11, slot_byte, 1'b0};
    end else if (tick && (state_reg == S_SLOTS)) begin
      sh_next = sh_shift;
    end else begin
      sh_next = sh_reg;
    end

    if (load_start) begin
      slot_next = '0;
    end else if (load_data) begin
      slot_next = slot_reg + 10'd1;
    end else begin
      slot_next = slot_reg;
    end

    // The start code does not consume an address, so slot k always reads address k.
    if (frame_end) begin
      addr_next = 10'd1;
    end else if (load_data) begin
      addr_next = addr_reg + 10'd1;
    end else begin
      addr_next = addr_reg;
    end

    if (enter_break) begin
      n_next = ((num_slots == '0) || (num_slots > SLOT_MAX)) ? SLOT_MAX : num_slots;
    end else begin
      n_next = n_reg;
    end

    if (state_next == S_SLOTS) begin
      dmx_next = sh_next[0];
    end else begin
      dmx_next = (state_next != S_BREAK);
    end

    busy_next = (state_next != S_WAIT);
    done_next = frame_end;
  end

  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_reg  <= CNT_TOP;
      bit_reg  <= '0;
      slot_reg <= '0;
      n_reg    <= SLOT_MAX;
      addr_reg <= 10'd1;
      sh_reg   <= '1;
      dmx_reg  <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      bit_reg  <= bit_next;
      slot_reg <= slot_next;
      n_reg    <= n_next;
      addr_reg <= addr_next;
      sh_reg   <= sh_next;
      dmx_reg  <= dmx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign slot_addr  = addr_reg;
  assign dmx_data   = dmx_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

`ifdef DMX_FRAME_COUNTER_EN
  logic [15:0] fc_reg;

  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      fc_reg <= 16'h0000;
    end else if (done_next) begin
      fc_reg <= fc_reg + 16'd1;
    end
  end

  assign frame_count = fc_reg;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dmx_framer.sv
// Self-checking bench for dmx_framer: expected line waveform is built bit-by-bit from the DMX frame rules.
// Small DIV and NUM_SLOTS keep full-frame runs short; frame_count expectation follows DMX_FRAME_COUNTER_EN.
module tb_dmx_framer;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 250_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int NSL    = 40;
  localparam int BRK    = 25;
  localparam int MAB    = 3;
  localparam int MTBP   = 2;
  localparam logic [7:0] SC = 8'h00;

  logic        CLK12 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        enable = 1'b0;
  logic        one_shot = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  num_slots = 10'd0;
  logic [9:0]  slot_addr;
  logic [7:0]  slot_byte;
  logic        dmx_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  logic [7:0]  mem [0:1023];
  int          n_checks = 0;
  int          n_fail = 0;
  int          fc_model = 0;

  dmx_framer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_SLOTS(NSL),
    .BREAK_BITS(BRK), .MAB_BITS(MAB), .MTBP_BITS(MTBP), .START_CODE(SC)
  ) dut (
    .CLK12(CLK12), .RESET_N(RESET_N), .enable(enable), .one_shot(one_shot),
    .start(start), .num_slots(num_slots), .slot_addr(slot_addr),
    .slot_byte(slot_byte), .dmx_data(dmx_data), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 CLK12 = ~CLK12;

  // Slot store with a registered read, like an inferred block RAM.
  always @(posedge CLK12) slot_byte <= mem[slot_addr];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic int clamp(input int v);
    return (v == 0 || v > NSL) ? NSL : v;
  endfunction

  function automatic logic [15:0] expected_fc();
`ifdef DMX_FRAME_COUNTER_EN
    return 16'(fc_model);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic fill_mem(input bit ident);
    for (int a = 0; a < 1024; a++) mem[a] = ident ? 8'(a) : 8'($urandom);
  endtask

  // Entered at the negedge showing the first BREAK clock; leaves at the negedge right after MTBP.
  task automatic run_frame(input int n_exp, input int num_at, input logic [9:0] num_val,
                           input int stop_at, input int stop_kind, input bit pulse_start,
                           input string tag);
    logic q[$];
    logic [7:0] b;
    logic got_first, exp_first;
    int total, done_idx, wave_err, done_err, busy_err, first_bad;
    q = {};
    repeat (BRK) q.push_back(1'b0);
    repeat (MAB) q.push_back(1'b1);
    for (int s = 0; s <= n_exp; s++) begin
      b = (s == 0) ? SC : mem[s];
      q.push_back(1'b0);
      for (int k = 0; k < 8; k++) q.push_back(b[k]);
      q.push_back(1'b1);
      q.push_back(1'b1);
    end
    repeat (MTBP) q.push_back(1'b1);
    total = q.size() * DIV;
    done_idx = (BRK + MAB + 11 * (n_exp + 1)) * DIV;
    wave_err = 0; done_err = 0; busy_err = 0; first_bad = -1;
    got_first = 1'b0; exp_first = 1'b0;
    for (int i = 0; i < total; i++) begin
      if (dmx_data !== q[i / DIV]) begin
        wave_err++;
        if (first_bad < 0) begin
          first_bad = i; got_first = dmx_data; exp_first = q[i / DIV];
        end
      end
      if (frame_done !== (i == done_idx)) done_err++;
      if (busy !== 1'b1) busy_err++;
      if (i == num_at) num_slots = num_val;
      if (i == stop_at) begin
        if (stop_kind == 1) enable = 1'b0;
        if (stop_kind == 2) one_shot = 1'b1;
      end
      start = pulse_start && (i % 53 == 7);
      @(negedge CLK12);
    end
    start = 1'b0;
    fc_model++;
    n_checks += 4;
    if (wave_err !== 0) begin
      n_fail++;
      $display("FAIL %s wave: %0d bad clocks, first at %0d got %b required %b", tag, wave_err, first_bad, got_first, exp_first);
    end
    if (done_err !== 0) begin
      n_fail++;
      $display("FAIL %s frame_done: %0d clocks wrong, required single pulse at clock %0d", tag, done_err, done_idx);
    end
    if (busy_err !== 0) begin
      n_fail++;
      $display("FAIL %s busy: low on %0d clocks, required high for %0d clocks", tag, busy_err, total);
    end
    if (frame_count !== expected_fc()) begin
      n_fail++;
      $display("FAIL %s frame_count: got %0d required %0d", tag, frame_count, expected_fc());
    end
    $display("frame %s: n=%0d clocks=%0d wave_err=%0d", tag, n_exp, total, wave_err);
  endtask

  task automatic run_idle(input int cycles, input bit pulse, input string tag);
    int bad_line, bad_addr;
    bad_line = 0; bad_addr = 0;
    for (int i = 0; i < cycles; i++) begin
      if (dmx_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad_line++;
      if (slot_addr !== 10'd1) bad_addr++;
      if (pulse) begin
        start = 1'($urandom);
        one_shot = 1'($urandom);
      end
      @(negedge CLK12);
    end
    start = 1'b0;
    n_checks += 2;
    if (bad_line !== 0) begin
      n_fail++;
      $display("FAIL %s idle_line: %0d clocks not mark/idle, required 0", tag, bad_line);
    end
    if (bad_addr !== 0) begin
      n_fail++;
      $display("FAIL %s idle_addr: %0d clocks slot_addr!=1, required 0", tag, bad_addr);
    end
    $display("idle %s: %0d clocks", tag, cycles);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; enable = 1'b0; one_shot = 1'b1; start = 1'b0; num_slots = 10'd0;
    fill_mem(1'b0);
    repeat (3) @(negedge CLK12);
    n_checks += 5;
    if (dmx_data !== 1'b1) begin n_fail++; $display("FAIL reset dmx_data: got %b required 1", dmx_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b required 0", busy); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b required 0", frame_done); end
    if (slot_addr !== 10'd1) begin n_fail++; $display("FAIL reset slot_addr: got %0d required 1", slot_addr); end
    if (frame_count !== 16'h0000) begin n_fail++; $display("FAIL reset frame_count: got %0d required 0", frame_count); end
    RESET_N = 1'b1;
    fc_model = 0;
    run_idle(10000, 1'b1, "reset_idle");
  endtask

  task automatic test_one_shot();
    fill_mem(1'b1);
    num_slots = 10'd4; enable = 1'b1; one_shot = 1'b1; start = 1'b1;
    @(negedge CLK12);
    start = 1'b0;
    run_frame(4, -1, 10'd0, -1, 0, 1'b0, "one_shot_n4");
    run_idle(200, 1'b0, "one_shot_after");
  endtask

  task automatic test_continuous();
    int nv;
    fill_mem(1'b0);
    nv = $urandom_range(1, NSL + 20);
    num_slots = 10'd0; enable = 1'b1; one_shot = 1'b0;
    @(negedge CLK12);
    run_frame(NSL, -1, 10'd0, -1, 0, 1'b0, "cont_f1");
    run_frame(NSL, $urandom_range(0, 400), 10'(nv), -1, 0, 1'b1, "cont_f2");
    run_frame(clamp(nv), $urandom_range(0, 100), 10'd0,
              (BRK + MAB + 11 * (clamp(nv) + 1)) * DIV + 1, 1, 1'b0, "cont_f3");
    run_idle(150, 1'b1, "cont_after");
  endtask

  task automatic test_enable_drop();
    int n;
    fill_mem(1'b0);
    num_slots = 10'd10; one_shot = 1'b0; enable = 1'b1;
    @(negedge CLK12);
    run_frame(10, -1, 10'd0, (BRK + MAB + 11 * 7 + 5) * DIV + 2, 1, 1'b1, "drop_enable");
    run_idle(150, 1'b1, "drop_after");
    n = $urandom_range(4, 15);
    num_slots = 10'(n); one_shot = 1'b0; enable = 1'b1;
    @(negedge CLK12);
    run_frame(n, -1, 10'd0, (BRK + MAB + 11 * 3 + 4) * DIV + 1, 2, 1'b0, "to_one_shot");
    run_idle(150, 1'b0, "one_shot_hold");
  endtask

  task automatic test_reset_mid_break();
    int k, n;
    fill_mem(1'b0);
    n = $urandom_range(1, NSL);
    num_slots = 10'(n); enable = 1'b1; one_shot = 1'b1; start = 1'b1;
    @(negedge CLK12);
    start = 1'b0;
    k = $urandom_range(5, BRK * DIV - 10);
    repeat (k) @(negedge CLK12);
    n_checks++;
    if (dmx_data !== 1'b0) begin n_fail++; $display("FAIL mid_break line: got %b required 0", dmx_data); end
    #1 RESET_N = 1'b0;
    #1;
    n_checks += 4;
    if (dmx_data !== 1'b1) begin n_fail++; $display("FAIL async_reset dmx_data: got %b required 1", dmx_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset busy: got %b required 0", busy); end
    if (slot_addr !== 10'd1) begin n_fail++; $display("FAIL async_reset slot_addr: got %0d required 1", slot_addr); end
    if (frame_count !== 16'h0000) begin n_fail++; $display("FAIL async_reset frame_count: got %0d required 0", frame_count); end
    $display("reset asserted %0d clocks into BREAK", k);
    @(negedge CLK12);
    RESET_N = 1'b1;
    fc_model = 0;
    run_idle(120, 1'b0, "post_reset");
    start = 1'b1;
    @(negedge CLK12);
    start = 1'b0;
    run_frame(n, -1, 10'd0, -1, 0, 1'b0, "post_reset_frame");
  endtask

  task automatic test_frame_count();
    int n;
    RESET_N = 1'b0;
    @(negedge CLK12);
    RESET_N = 1'b1;
    fc_model = 0;
    enable = 1'b1; one_shot = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_mem(1'b0);
      n = (f == 2) ? NSL + 1 + $urandom_range(0, 100) : $urandom_range(1, NSL);
      num_slots = 10'(n); start = 1'b1;
      @(negedge CLK12);
      start = 1'b0;
      run_frame(clamp(n), -1, 10'd0, -1, 0, 1'b1, $sformatf("count_f%0d", f));
      run_idle(30, 1'b0, "count_gap");
    end
    n_checks++;
`ifdef DMX_FRAME_COUNTER_EN
    if (frame_count !== 16'd3) begin n_fail++; $display("FAIL count_total frame_count: got %0d required 3", frame_count); end
`else
    if (frame_count !== 16'd0) begin n_fail++; $display("FAIL count_total frame_count: got %0d required 0", frame_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_continuous();
    test_enable_drop();
    test_reset_mid_break();
    test_frame_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
